gb_irq_ctrl: RTL and testbench
==============================

Name: gb_irq_ctrl

Overview:
Parametrised interrupt controller that replaces the fixed 5-source IF/IE logic in the Game Boy top level. It has N sources, each with a per-source edge/level mode and a configurable input synchroniser depth. It implements a CPU-visible register file (IF, IE, MODE, PENDING), drives the CPU active-low INT line, and supplies a priority-encoded RST vector during the acknowledge cycle. The vector is latched and the acknowledged flag is cleared on ack release.

Parameters:
NUM_IRQ, 5, number of sources (1..8); bit 0 has the highest priority.
SYNC_STAGES, 0, flip-flop stages on each src input (0..3); 0 means src is already synchronous to clk.
VEC_BASE, 8'h40, vector of source 0.
VEC_STRIDE, 8'h08, vector spacing between consecutive sources.
IDLE_VEC, 8'h55, vector returned when an ack finds nothing pending and enabled.
MODE_RESET, 8'h00, reset value of MODE[NUM_IRQ-1:0].

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
src  in  NUM_IRQ  active-high interrupt request lines
cpu_sel  in  1  register block selected
cpu_addr  in  2  0=IF, 1=IE, 2=MODE, 3=PENDING (read-only)
cpu_wr  in  1  write strobe, acted on every clk while cpu_sel is high
cpu_di  in  8  write data
cpu_do  out  8  read data, combinational
irq_ack  in  1  CPU acknowledge (IORQ and M1 both low)
irq_vec  out  8  vector presented to the CPU
irq_n  out  1  low while (IF & IE) != 0

Behaviour:
- Reset (async assert, sync release):
  - IF=0, IE=0, MODE=MODE_RESET.
  - Synchroniser flops = 0; edge-history register = all 1s, so a src held high through reset never produces an edge.
  - Latched vector = IDLE_VEC, ack history = 0, irq_n=1.
- Synchroniser: s[i] is src[i] delayed by SYNC_STAGES clocks.
- Source set condition:
  - MODE[i]=0 (edge): set IF[i] on a clk edge where s[i]=1 and prev[i]=0. prev <= s every clk.
  - MODE[i]=1 (level): set IF[i] on every clk edge where s[i]=1.
  - Latency: src first sampled high at edge k gives IF[i]=1 after edge k+SYNC_STAGES.
- irq_n = ~|(IF & IE), driven from registers only; no combinational path from src.
- Priority encode: p = lowest index with IF[p]&IE[p]=1. Vector = VEC_BASE + p*VEC_STRIDE (8-bit, wraps modulo 256). If no bit qualifies, vector = IDLE_VEC.
- Ack handshake:
  - On the clk where irq_ack=1 and ack_d=0 (rising), latch the vector and the index p (or "none").
  - irq_vec = latched vector while irq_ack=1. Otherwise irq_vec shows the live encode.
  - The latched value is frozen for the whole ack, even if IF/IE change.
  - On the clk where irq_ack=0 and ack_d=1 (falling), clear IF[p_latched]. If "none" was latched, nothing is cleared.
  - An ack of any length ≥1 cycle is valid.
- CPU write (cpu_sel & cpu_wr):
  - Addr 0 writes IF <= cpu_di[NUM_IRQ-1:0].
  - Addr 1 writes IE.
  - Addr 2 writes MODE.
  - Addr 3 is ignored.
  - Bits at or above NUM_IRQ are discarded.
- Precedence for the same IF bit in the same clk, highest first:
  1. CPU write to IF.
  2. Source set.
  3. Ack clear.
  A new event coinciding with the ack clear is therefore kept. A level source still high re-sets its flag on the next clk.
- Changing MODE from 1 to 0 does not clear IF; prev keeps tracking s continuously.
- Reads: cpu_do = {fill 1s above NUM_IRQ, reg}. Addr 3 returns IF&IE. When cpu_sel=0, cpu_do = 8'hFF.
- Reset asserted mid-ack: all state returns to reset values immediately; the pending clear is lost.

Test Plan:
- Reset then IE=5'h1F, SYNC_STAGES=2; pulse src[2] high for 1 cycle at edge k → IF=5'h04 after edge k+2; irq_n=0; cpu_do at addr 0 = 8'hE4.
- IF=5'h06, IE=5'h1F; ack high for 3 clk → irq_vec=8'h48 throughout, including when src[0] sets IF[0] mid-ack; after ack falls, IF=5'h05 and the next ack gives 8'h40.
- IE=0, IF=5'h1F; ack pulse → irq_vec=8'h55, IF unchanged, irq_n=1.
- MODE=5'h10, IE=5'h10; hold src[4] high; ack/release → IF[4] re-sets 1 clk after the clear; drop src → the next ack clears it permanently.
- Same clk: ack falling clears IF[1] while an edge on src[1] arrives → IF[1]=1. Repeat with a CPU write of IF=0 in that clk → IF=0.
- NUM_IRQ=8, VEC_BASE=8'hF0, VEC_STRIDE=8'h04: pending only bit 7 → vec=8'h0C (wrap). Assert reset_n=0 mid-ack → irq_vec=IDLE_VEC and IF=0 asynchronously.

Source files
------------

// File: rtl/gb_irq_ctrl.sv
// Parametrised interrupt controller: synchronised edge/level sources, IF/IE/MODE register file,
// active-low INT and a priority-encoded vector latched for the duration of the acknowledge.
module gb_irq_ctrl #(
   parameter int         NUM_IRQ     = 5,
   parameter int         SYNC_STAGES = 0,
   parameter logic [7:0] VEC_BASE    = 8'h40,
   parameter logic [7:0] VEC_STRIDE  = 8'h08,
   parameter logic [7:0] IDLE_VEC    = 8'h55,
   parameter logic [7:0] MODE_RESET  = 8'h00
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_IRQ-1:0] src,
   input  logic               cpu_sel,
   input  logic [1:0]         cpu_addr,
   input  logic               cpu_wr,
   input  logic [7:0]         cpu_di,
   output logic [7:0]         cpu_do,
   input  logic               irq_ack,
   output logic [7:0]         irq_vec,
   output logic               irq_n
);

   localparam int N = NUM_IRQ;

   logic [N-1:0] src_s;
   logic [N-1:0] if_q, if_d, ie_q, ie_d, mode_q, mode_d, prev_q;
   logic [N-1:0] pend_s, set_s, clr_s;
   logic         ack_q, rise_s, fall_s, hit_s, hit_lat_q;
   logic [2:0]   idx_s, idx_lat_q;
   logic [7:0]   live_vec_s, vec_lat_q, rd_s;

   function automatic logic [7:0] pad_ones(input logic [N-1:0] v);
      logic [7:0] r;
      r        = 8'hFF;
      r[N-1:0] = v;
      return r;
   endfunction

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign src_s = src;
      end else begin : g_sync
         logic [N-1:0] sync_q [SYNC_STAGES];
         // Input synchroniser chain
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            end else begin
               sync_q[0] <= src;
               for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            end
         end
         assign src_s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   assign pend_s = if_q & ie_q;
   assign rise_s = irq_ack & ~ack_q;
   assign fall_s = ~irq_ack & ack_q;
   // Edge mode needs a 0->1 on the synchronised line; level mode sets while high
   assign set_s  = src_s & (mode_q | ~prev_q);

   // Priority encoder: lowest pending index wins
   always_comb begin
      hit_s = 1'b0;
      idx_s = 3'd0;
      for (int i = N - 1; i >= 0; i--) begin
         hit_s = hit_s | pend_s[i];
         idx_s = pend_s[i] ? 3'(i) : idx_s;
      end
      if (hit_s) begin
         live_vec_s = VEC_BASE + ({5'd0, idx_s} * VEC_STRIDE);
      end else begin
         live_vec_s = IDLE_VEC;
      end
   end

   // Next-state of the register file: CPU write beats source set beats ack clear
   always_comb begin
      for (int i = 0; i < N; i++) begin
         clr_s[i] = fall_s & hit_lat_q & (idx_lat_q == 3'(i));
      end
      if_d   = (if_q & ~clr_s) | set_s;
      ie_d   = ie_q;
      mode_d = mode_q;
      if (cpu_sel && cpu_wr) begin
         case (cpu_addr)
            2'd0:    if_d   = cpu_di[N-1:0];
            2'd1:    ie_d   = cpu_di[N-1:0];
            2'd2:    mode_d = cpu_di[N-1:0];
            default: mode_d = mode_q;
         endcase
      end else begin
         mode_d = mode_q;
      end
   end

   // State registers and ack-time vector latch
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         if_q      <= '0;
         ie_q      <= '0;
         mode_q    <= MODE_RESET[N-1:0];
         prev_q    <= '1;
         ack_q     <= 1'b0;
         vec_lat_q <= IDLE_VEC;
         idx_lat_q <= 3'd0;
         hit_lat_q <= 1'b0;
      end else begin
         if_q   <= if_d;
         ie_q   <= ie_d;
         mode_q <= mode_d;
         prev_q <= src_s;
         ack_q  <= irq_ack;
         if (rise_s) begin
            vec_lat_q <= live_vec_s;
            idx_lat_q <= idx_s;
            hit_lat_q <= hit_s;
         end
      end
   end

   // Read mux; unused high bits read as 1
   always_comb begin
      case (cpu_addr)
         2'd0:    rd_s = pad_ones(if_q);
         2'd1:    rd_s = pad_ones(ie_q);
         2'd2:    rd_s = pad_ones(mode_q);
         default: rd_s = pad_ones(pend_s);
      endcase
      if (cpu_sel) begin
         cpu_do = rd_s;
      end else begin
         cpu_do = 8'hFF;
      end
   end

   // In the first ack cycle the live encode equals the value about to be latched
   assign irq_vec = (irq_ack && ack_q) ? vec_lat_q : live_vec_s;
   assign irq_n   = ~|pend_s;

endmodule

// File: tb/tb_gb_irq_ctrl.sv
// Scoreboard bench for gb_irq_ctrl: a reference model predicts outputs per cycle into a queue,
// and a negedge monitor compares them against the DUT.
module tb_gb_irq_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [4:0] src = '0;
   logic       cpu_sel = 1'b0, cpu_wr = 1'b0, irq_ack = 1'b0;
   logic [1:0] cpu_addr = 2'd0;
   logic [7:0] cpu_di = 8'h00;
   logic [7:0] cpu_do, irq_vec;
   logic       irq_n;

   logic [7:0] src8 = 8'h00;
   logic       sel8 = 1'b0, wr8 = 1'b0, ack8 = 1'b0;
   logic [1:0] addr8 = 2'd0;
   logic [7:0] di8 = 8'h00;
   logic [7:0] do8, vec8;
   logic       n8;

   always #5 clk = ~clk;

   gb_irq_ctrl #(.NUM_IRQ(5), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n), .src(src), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr),
      .cpu_wr(cpu_wr), .cpu_di(cpu_di), .cpu_do(cpu_do), .irq_ack(irq_ack),
      .irq_vec(irq_vec), .irq_n(irq_n));

   gb_irq_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(0), .VEC_BASE(8'hF0), .VEC_STRIDE(8'h04)) dut8 (
      .clk(clk), .reset_n(reset_n), .src(src8), .cpu_sel(sel8), .cpu_addr(addr8),
      .cpu_wr(wr8), .cpu_di(di8), .cpu_do(do8), .irq_ack(ack8),
      .irq_vec(vec8), .irq_n(n8));

   typedef struct {
      logic [7:0] do_v;
      logic [7:0] vec;
      logic       n;
      string      tag;
   } exp_t;

   exp_t q[$];
   exp_t q8[$];
   int   n_chk = 0;
   int   n_fail = 0;

   // reference model state
   logic [4:0] m_if, m_ie, m_mode, m_prev;
   logic       m_ackd;
   logic [7:0] m_lvec;
   int         m_lidx;
   logic [4:0] hist[$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk({e.tag, ".cpu_do"}, cpu_do, e.do_v);
         chk({e.tag, ".irq_vec"}, irq_vec, e.vec);
         chk({e.tag, ".irq_n"}, {7'd0, irq_n}, {7'd0, e.n});
      end
      if (q8.size() > 0) begin
         exp_t e;
         e = q8.pop_front();
         chk({e.tag, ".cpu_do8"}, do8, e.do_v);
         chk({e.tag, ".irq_vec8"}, vec8, e.vec);
         chk({e.tag, ".irq_n8"}, {7'd0, n8}, {7'd0, e.n});
      end
   end

   function automatic int lowest(input logic [4:0] p);
      for (int i = 0; i < 5; i++) if (p[i]) return i;
      return -1;
   endfunction

   function automatic logic [7:0] vec_of(input int p);
      int v;
      if (p < 0) return 8'h55;
      v = (64 + p * 8) % 256;
      return v[7:0];
   endfunction

   task automatic model_reset();
      m_if = '0; m_ie = '0; m_mode = '0; m_prev = 5'h1F;
      m_ackd = 1'b0; m_lvec = 8'h55; m_lidx = -1;
      hist = '{5'd0, 5'd0};
   endtask

   task automatic model_edge();
      logic [4:0] s, set, clr, nif;
      if (!reset_n) begin
         model_reset();
         return;
      end
      s = hist.pop_front();
      hist.push_back(src);
      clr = '0;
      if (irq_ack && !m_ackd) begin
         m_lidx = lowest(m_if & m_ie);
         m_lvec = vec_of(m_lidx);
      end
      if (!irq_ack && m_ackd && m_lidx >= 0) clr[m_lidx] = 1'b1;
      for (int i = 0; i < 5; i++) set[i] = s[i] && (m_mode[i] || !m_prev[i]);
      nif = (m_if & ~clr) | set;
      if (cpu_sel && cpu_wr) begin
         case (cpu_addr)
            2'd0: nif = cpu_di[4:0];
            2'd1: m_ie = cpu_di[4:0];
            2'd2: m_mode = cpu_di[4:0];
            default: ;
         endcase
      end
      m_if = nif;
      m_prev = s;
      m_ackd = irq_ack;
   endtask

   task automatic cyc(input logic [4:0] s_i, input logic sel, input logic [1:0] a,
                      input logic wr, input logic [7:0] di, input logic ack, input string tag);
      exp_t e;
      logic [4:0] pend;
      src = s_i; cpu_sel = sel; cpu_addr = a; cpu_wr = wr; cpu_di = di; irq_ack = ack;
      if (!reset_n) model_reset();
      pend = m_if & m_ie;
      e.n = (pend == 5'd0);
      e.vec = (ack && m_ackd) ? m_lvec : vec_of(lowest(pend));
      if (!sel) e.do_v = 8'hFF;
      else begin
         case (a)
            2'd0: e.do_v = {3'b111, m_if};
            2'd1: e.do_v = {3'b111, m_ie};
            2'd2: e.do_v = {3'b111, m_mode};
            default: e.do_v = {3'b111, pend};
         endcase
      end
      e.tag = tag;
      q.push_back(e);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic cyc8(input logic sel, input logic [1:0] a, input logic wr, input logic [7:0] di,
                       input logic ack, input logic [7:0] x_do, input logic [7:0] x_vec,
                       input logic x_n, input string tag);
      exp_t e;
      sel8 = sel; addr8 = a; wr8 = wr; di8 = di; ack8 = ack;
      e.do_v = x_do; e.vec = x_vec; e.n = x_n; e.tag = tag;
      q8.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ack_left;
      model_reset();
      @(posedge clk); #1;
      // reset state
      for (int i = 0; i < 3; i++) cyc(5'h1F, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "reset");
      reset_n = 1'b1;
      cyc(5'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "rst_rel");
      // single-cycle pulse through the 2-stage synchroniser
      cyc(5'h00, 1'b1, 2'd1, 1'b1, 8'h1F, 1'b0, "wr_ie");
      cyc(5'h04, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "pulse");
      for (int i = 0; i < 4; i++) cyc(5'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "sync_lat");
      // frozen vector during a long ack
      cyc(5'h00, 1'b1, 2'd0, 1'b1, 8'h06, 1'b0, "wr_if6");
      cyc(5'h01, 1'b1, 2'd0, 1'b0, 8'h00, 1'b1, "ack_a");
      cyc(5'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b1, "ack_b");
      cyc(5'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b1, "ack_c");
      cyc(5'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "ack_rel");
      cyc(5'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b1, "ack2");
      cyc(5'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "ack2_rel");
      cyc(5'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "after2");
      // nothing enabled
      cyc(5'h00, 1'b1, 2'd1, 1'b1, 8'h00, 1'b0, "ie0");
      cyc(5'h00, 1'b1, 2'd0, 1'b1, 8'h1F, 1'b0, "if1f");
      cyc(5'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b1, "idle_ack");
      cyc(5'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "idle_rel");
      cyc(5'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "idle_chk");
      // level source re-sets its flag
      cyc(5'h00, 1'b1, 2'd2, 1'b1, 8'h10, 1'b0, "mode10");
      cyc(5'h00, 1'b1, 2'd1, 1'b1, 8'h10, 1'b0, "ie10");
      cyc(5'h10, 1'b1, 2'd0, 1'b1, 8'h00, 1'b0, "if0");
      for (int i = 0; i < 3; i++) cyc(5'h10, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "lvl_hold");
      cyc(5'h10, 1'b1, 2'd0, 1'b0, 8'h00, 1'b1, "lvl_ack");
      for (int i = 0; i < 3; i++) cyc(5'h10, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "lvl_reset");
      for (int i = 0; i < 3; i++) cyc(5'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "lvl_drop");
      cyc(5'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b1, "lvl_ack2");
      for (int i = 0; i < 2; i++) cyc(5'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "lvl_gone");
      // source edge coincident with ack clear keeps the flag
      cyc(5'h00, 1'b1, 2'd2, 1'b1, 8'h00, 1'b0, "mode0");
      cyc(5'h00, 1'b1, 2'd1, 1'b1, 8'h02, 1'b0, "ie02");
      cyc(5'h00, 1'b1, 2'd0, 1'b1, 8'h02, 1'b0, "if02");
      cyc(5'h02, 1'b1, 2'd0, 1'b0, 8'h00, 1'b1, "coin_a");
      cyc(5'h02, 1'b1, 2'd0, 1'b0, 8'h00, 1'b1, "coin_b");
      cyc(5'h02, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "coin_fall");
      cyc(5'h02, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "coin_chk");
      // same again but a CPU write of IF=0 wins
      for (int i = 0; i < 3; i++) cyc(5'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "coin_low");
      cyc(5'h02, 1'b1, 2'd0, 1'b0, 8'h00, 1'b1, "wr_a");
      cyc(5'h02, 1'b1, 2'd0, 1'b0, 8'h00, 1'b1, "wr_b");
      cyc(5'h02, 1'b1, 2'd0, 1'b1, 8'h00, 1'b0, "wr_fall");
      cyc(5'h02, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "wr_chk");
      // reset in the middle of an ack
      cyc(5'h00, 1'b1, 2'd1, 1'b1, 8'h1F, 1'b0, "pre_rst_ie");
      cyc(5'h00, 1'b1, 2'd0, 1'b1, 8'h08, 1'b0, "pre_rst_if");
      cyc(5'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b1, "rst_ack");
      reset_n = 1'b0;
      cyc(5'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b1, "rst_mid");
      cyc(5'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "rst_mid2");
      reset_n = 1'b1;
      cyc(5'h00, 1'b1, 2'd3, 1'b0, 8'h00, 1'b0, "rst_after");
      // randomized traffic
      ack_left = 0;
      for (int i = 0; i < 400; i++) begin
         logic ack_v, wr_v;
         if (ack_left > 0) ack_left--;
         else if ($urandom_range(0, 5) == 0) ack_left = $urandom_range(1, 4);
         ack_v = (ack_left > 0);
         wr_v = ($urandom_range(0, 5) == 0);
         cyc(5'($urandom), 1'($urandom_range(0, 7) != 0), 2'($urandom), wr_v,
             8'($urandom), ack_v, "rand");
      end
      cyc(5'h00, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, "rand_end");
      // 8-source instance: vector wrap-around
      cyc8(1'b1, 2'd1, 1'b1, 8'hFF, 1'b0, 8'h00, 8'h55, 1'b1, "w8_ie");
      cyc8(1'b1, 2'd0, 1'b1, 8'h80, 1'b0, 8'h00, 8'h55, 1'b1, "w8_if");
      cyc8(1'b1, 2'd3, 1'b0, 8'h00, 1'b0, 8'h80, 8'h0C, 1'b0, "w8_pend");
      cyc8(1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 8'h80, 8'h0C, 1'b0, "w8_ack");
      cyc8(1'b1, 2'd0, 1'b1, 8'h81, 1'b1, 8'h80, 8'h0C, 1'b0, "w8_ackwr");
      cyc8(1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 8'h81, 8'h0C, 1'b0, "w8_frozen");
      cyc8(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 8'h81, 8'hF0, 1'b0, "w8_rel");
      cyc8(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 8'h01, 8'hF0, 1'b0, "w8_clr7");
      cyc8(1'b1, 2'd0, 1'b1, 8'h08, 1'b0, 8'h01, 8'hF0, 1'b0, "w8_if8");
      cyc8(1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 8'hFF, 8'hFC, 1'b0, "w8_idx3");
      repeat (2) @(posedge clk);
      n_chk++;
      if (q.size() != 0 || q8.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d/%0d entries left, expected 0", q.size(), q8.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
